// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer: fetches an instruction on memory port A, latches it,
// and steps it through the datapath while holding the status flags used by conditional jumps.
module instr_sequencer #(
  parameter logic [3:0]  HALT_OP = 4'b1111,
  parameter int unsigned FLAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       mem_out_a,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic              stall,
  output logic [15:0]       opcode,
  output logic [3:0]        mux_A_sel,
  output logic [3:0]        mux_B_sel,
  output logic              imm_sel,
  output logic [15:0]       imm_val,
  output logic              pc_sel,
  output logic              pc_en,
  output logic              pc_ld,
  output logic              w_en_a,
  output logic              w_en_b,
  output logic [15:0]       reg_en,
  output logic              wb_sel,
  output logic              flag_en,
  output logic [FLAG_W-1:0] psr,
  output logic              halted
);

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 4;

  localparam logic [3:0] OP_REG  = 4'b0000;
  localparam logic [3:0] OP_MEM  = 4'b0100;
  localparam logic [3:0] OP_CMPI = 4'b1011;
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JCOND = 4'b1100;
  localparam logic [3:0] EXT_CMP   = 4'b1011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_LD_WB  = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] ir;
  logic [3:0]  op;
  logic [3:0]  ext;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic        is_imm;
  logic        cond;
  logic [15:0] ra_onehot;

  assign op        = ir[15:12];
  assign ra        = ir[11:8];
  assign ext       = ir[7:4];
  assign rb        = ir[3:0];
  assign opcode    = ir;
  assign imm_val   = {{8{ir[7]}}, ir[7:0]};
  assign w_en_b    = 1'b0;
  assign ra_onehot = 16'(1) << ra;
  assign is_imm    = op inside {4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b1001, 4'b1011, 4'b1101};

  // Branch condition evaluated against the latched flags, never the live ALU flags.
  always_comb begin
    cond = 1'b0;
    case (ra)
      4'd0:    cond = psr[FLAG_Z];
      4'd1:    cond = ~psr[FLAG_Z];
      4'd2:    cond = psr[FLAG_C];
      4'd3:    cond = ~psr[FLAG_C];
      4'd6:    cond = psr[FLAG_N];
      4'd7:    cond = ~psr[FLAG_N];
      4'd14:   cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      ir    <= '0;
      psr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) ir <= mem_out_a;
      if (flag_en) psr <= alu_flags;
    end
  end

  // Next state and control decode from state + latched instruction.
  always_comb begin
    state_nxt = state;
    mux_A_sel = 4'd0;
    mux_B_sel = 4'd0;
    imm_sel   = 1'b0;
    pc_sel    = 1'b0;
    pc_en     = 1'b0;
    pc_ld     = 1'b0;
    w_en_a    = 1'b0;
    reg_en    = 16'd0;
    wb_sel    = 1'b0;
    flag_en   = 1'b0;
    halted    = 1'b0;
    case (state)
      S_FETCH: begin
        pc_sel = 1'b1;
        if (!stall) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        state_nxt = (mem_out_a[15:12] == HALT_OP) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (op == OP_REG || is_imm) begin
          mux_A_sel = ra;
          mux_B_sel = rb;
          imm_sel   = is_imm;
          flag_en   = 1'b1;
          pc_en     = 1'b1;
          if (!(op == OP_REG && ext == EXT_CMP) && op != OP_CMPI) reg_en = ra_onehot;
          state_nxt = S_FETCH;
        end else if (op == OP_MEM && ext == EXT_LOAD) begin
          mux_A_sel = rb;
          if (!stall) state_nxt = S_LD_WB;
        end else if (op == OP_MEM && ext == EXT_STOR) begin
          mux_A_sel = rb;
          mux_B_sel = ra;
          if (!stall) begin
            w_en_a    = 1'b1;
            pc_en     = 1'b1;
            state_nxt = S_FETCH;
          end
        end else if (op == OP_MEM && ext == EXT_JCOND) begin
          mux_A_sel = rb;
          pc_en     = 1'b1;
          pc_ld     = cond;
          state_nxt = S_FETCH;
        end else begin
          pc_en     = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_LD_WB: begin
        mux_A_sel = rb;
        wb_sel    = 1'b1;
        reg_en    = ra_onehot;
        pc_en     = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
    // A reset cycle must never leave a write or PC update behind.
    if (reset) begin
      reg_en  = 16'd0;
      w_en_a  = 1'b0;
      pc_en   = 1'b0;
      pc_ld   = 1'b0;
      flag_en = 1'b0;
    end
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle control unit for the 16-bit datapath. It fetches an instruction from memory port A at the program counter, latches it, and sequences one instruction through the datapath.
- Drives the ALU opcode, register-mux selects, register-bank write enables, memory write enable, PC controls and writeback select.
- Holds the processor status flags for conditional jumps, and supports a stall input for memory sharing with a future port-B/VGA master.

Parameters:
- HALT_OP, 4'b1111, ir[15:12] value that enters HALT.
- FLAG_W, 5, width of ALU flag vector; bit order {N,Z,F,L,C} = [4:0].

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; state->FETCH, ir/psr cleared
- mem_out_a  in  16  memory port A read data (valid one cycle after address)
- alu_flags  in  5  combinational ALU flags for current operands
- stall  in  1  memory port busy; freezes FETCH and memory-access EXEC
- opcode  out  16  instruction word to ALU (= ir)
- mux_A_sel  out  4  register select A
- mux_B_sel  out  4  register select B
- imm_sel  out  1  ALU B operand = imm_val
- imm_val  out  16  sign-extended ir[7:0]
- pc_sel  out  1  1: memory address = PC; 0: address = mux_A_out
- pc_en  out  1  PC advance enable
- pc_ld  out  1  with pc_en: PC <= mux_A_out
- w_en_a  out  1  memory port A write
- w_en_b  out  1  tied 0
- reg_en  out  16  one-hot register write enable
- wb_sel  out  1  register write data: 0 ALU, 1 mem_out_a
- flag_en  out  1  psr <= alu_flags this edge
- psr  out  5  latched status flags
- halted  out  1  high in HALT

Behaviour:
- States: FETCH, DECODE, EXEC, LD_WB, HALT. Moore-style control from state+ir; all outputs combinational.
- Reset: state=FETCH, ir=0, psr=0. Outputs in FETCH: pc_sel=1, everything else 0.
- FETCH: pc_sel=1. If stall, hold; else go to DECODE.
- DECODE: ir <= mem_out_a. Go to EXEC, or to HALT if ir[15:12]==HALT_OP (mem_out_a checked directly).
- EXEC, decoded by ir[15:12] op and ir[7:4] ext:
  - op 0000, register ALU: mux_A_sel=ir[11:8], mux_B_sel=ir[3:0], flag_en=1, pc_en=1, reg_en[ir[11:8]]=1 except ext 1011 (CMP, no write). Next FETCH.
  - op in {0001,0010,0011,0101,1001,1011,1101}, immediate ALU: same as register ALU with imm_sel=1; CMPI (1011) does not write. Next FETCH.
  - op 0100 ext 0000, LOAD: mux_A_sel=ir[3:0], pc_sel=0. If stall, hold; else go to LD_WB.
  - op 0100 ext 0100, STOR: mux_A_sel=ir[3:0] (address), mux_B_sel=ir[11:8] (data), pc_sel=0, w_en_a=1, pc_en=1. Next FETCH. If stall: w_en_a=0, pc_en=0, hold.
  - op 0100 ext 1100, JCOND: mux_A_sel=ir[3:0], pc_en=1, pc_ld=cond. cond codes on ir[11:8]: 0 EQ Z=1; 1 NE Z=0; 2 CS C=1; 3 CC C=0; 6 GT N=1; 7 LE N=0; 14 UC always; others never. Next FETCH.
  - any other encoding: NOP, pc_en=1 only.
- LD_WB: mux_A_sel=ir[3:0], pc_sel=0, wb_sel=1, reg_en[ir[11:8]]=1, pc_en=1. Next FETCH.
- HALT: all enables 0, halted=1, stays until reset.
- Latency: ALU/store/jump 3 cycles, load 4, stall cycles added. reg_en is always one-hot or zero.
- psr updates only when flag_en=1. JCOND reads psr, not alu_flags.
- Reset wins over stall in every state; mid-instruction reset aborts with no writes.

Test Plan:
- Reset then FETCH with mem_out_a=16'h0152 (ADD R1,R2) -> DECODE ir=0152; EXEC reg_en=16'h0002, mux_A_sel=1, mux_B_sel=2, flag_en=1, pc_en=1; back in FETCH on cycle 4.
- CMPI 16'hB305 with alu_flags=5'b01000 -> imm_sel=1, imm_val=16'h0005, reg_en=0, psr=5'b01000 after EXEC.
- psr Z=1, JCOND 16'h40C7 (EQ, R7) -> pc_en=1, pc_ld=1. Repeat with Z=0 -> pc_ld=0, pc_en=1.
- LOAD 16'h4504 -> EXEC pc_sel=0, mux_A_sel=4; LD_WB wb_sel=1, reg_en=16'h0020; stall=1 for 2 cycles in EXEC extends latency by exactly 2.
- STOR 16'h4346 with stall high one cycle -> w_en_a=0 while stalled, then a single w_en_a=1 cycle with mux_B_sel=3, mux_A_sel=6.
- mem_out_a=16'hF000 -> halted=1, no enables ever; reset asserted in EXEC of an ADD -> no reg_en pulse, state FETCH, psr=0.
